// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use hazard detection and halt drain FSM.
// A halt instruction captured into EX starts a three-cycle drain, after which
// the stage sits in a sticky halted state until reset.
// Optional feature macro: LOAD_USE_STALL_EN enables the load-use stall
// detector; without it, load-use scheduling is left to software.
module id_ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        id_valid,
    input  logic [12:0] id_ctrl,
    input  logic [31:0] id_pc,
    input  logic [31:0] id_rd1,
    input  logic [31:0] id_rd2,
    input  logic [31:0] id_imm,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic [4:0]  id_rd,
    input  logic [9:0]  id_funct,
    input  logic        ex_flush,
    output logic        ex_valid,
    output logic [12:0] ex_ctrl,
    output logic [31:0] ex_pc,
    output logic [31:0] ex_rd1,
    output logic [31:0] ex_rd2,
    output logic [31:0] ex_imm,
    output logic [4:0]  ex_rs1,
    output logic [4:0]  ex_rs2,
    output logic [4:0]  ex_rd,
    output logic [9:0]  ex_funct,
    output logic        stall,
    output logic        halted
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic        halted_q, halted_d;
    logic        ex_valid_q, ex_valid_d;
    logic [12:0] ex_ctrl_q, ex_ctrl_d;
    logic [31:0] ex_pc_q, ex_pc_d;
    logic [31:0] ex_rd1_q, ex_rd1_d;
    logic [31:0] ex_rd2_q, ex_rd2_d;
    logic [31:0] ex_imm_q, ex_imm_d;
    logic [4:0]  ex_rs1_q, ex_rs1_d;
    logic [4:0]  ex_rs2_q, ex_rs2_d;
    logic [4:0]  ex_rd_q, ex_rd_d;
    logic [9:0]  ex_funct_q, ex_funct_d;
    logic        hz;
    logic        bubble;

`ifdef LOAD_USE_STALL_EN
    // A load in EX whose destination feeds the ID instruction must wait one cycle.
    assign hz = ex_valid_q & ex_ctrl_q[4] & (ex_rd_q != 5'd0) & id_valid &
                ((ex_rd_q == id_rs1) | (ex_rd_q == id_rs2));
`else
    assign hz = 1'b0;
`endif

    // Front end freezes on an unflushed load-use hazard and for the whole drain/halt period.
    assign stall  = ~reset & (((state_q == RUN) & hz & ~ex_flush) | (state_q != RUN));

    // Anything other than a clean RUN capture inserts a bubble into EX.
    assign bubble = ex_flush | hz | (state_q != RUN);

    // Next-state computation for the FSM and all EX payload registers.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves a latch behind.
        state_d    = state_q;
        cnt_d      = cnt_q;
        ex_valid_d = ex_valid_q;
        ex_ctrl_d  = ex_ctrl_q;
        ex_pc_d    = ex_pc_q;
        ex_rd1_d   = ex_rd1_q;
        ex_rd2_d   = ex_rd2_q;
        ex_imm_d   = ex_imm_q;
        ex_rs1_d   = ex_rs1_q;
        ex_rs2_d   = ex_rs2_q;
        ex_rd_d    = ex_rd_q;
        ex_funct_d = ex_funct_q;

        if (reset) begin
            state_d    = RUN;
            cnt_d      = 2'd0;
            ex_valid_d = 1'b0;
            ex_ctrl_d  = 13'd0;
            ex_pc_d    = 32'd0;
            ex_rd1_d   = 32'd0;
            ex_rd2_d   = 32'd0;
            ex_imm_d   = 32'd0;
            ex_rs1_d   = 5'd0;
            ex_rs2_d   = 5'd0;
            ex_rd_d    = 5'd0;
            ex_funct_d = 10'd0;
        end else begin
            // Drain counts down every cycle regardless of flush or hazard.
            if (state_q == DRAIN) begin
                if (cnt_q <= 2'd1) begin
                    state_d = HALTED;
                    cnt_d   = 2'd0;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end

            if (bubble) begin
                // Payload holds; only validity and controls are cleared.
                ex_valid_d = 1'b0;
                ex_ctrl_d  = 13'd0;
            end else begin
                ex_valid_d = id_valid;
                ex_ctrl_d  = id_valid ? id_ctrl : 13'd0;
                ex_pc_d    = id_pc;
                ex_rd1_d   = id_rd1;
                ex_rd2_d   = id_rd2;
                ex_imm_d   = id_imm;
                ex_rs1_d   = id_rs1;
                ex_rs2_d   = id_rs2;
                ex_rd_d    = id_rd;
                ex_funct_d = id_funct;
                // Only a halt that actually enters EX starts the drain.
                if (id_valid & id_ctrl[12]) begin
                    state_d = DRAIN;
                    cnt_d   = 2'd3;
                end
            end
        end

        halted_d = (state_d == HALTED);
    end

    // State and pipeline registers; reset is folded into the _d logic above.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
        state_q    <= state_d;
        cnt_q      <= cnt_d;
        halted_q   <= halted_d;
        ex_valid_q <= ex_valid_d;
        ex_ctrl_q  <= ex_ctrl_d;
        ex_pc_q    <= ex_pc_d;
        ex_rd1_q   <= ex_rd1_d;
        ex_rd2_q   <= ex_rd2_d;
        ex_imm_q   <= ex_imm_d;
        ex_rs1_q   <= ex_rs1_d;
        ex_rs2_q   <= ex_rs2_d;
        ex_rd_q    <= ex_rd_d;
        ex_funct_q <= ex_funct_d;
    end

    assign ex_valid = ex_valid_q;
    assign ex_ctrl  = ex_ctrl_q;
    assign ex_pc    = ex_pc_q;
    assign ex_rd1   = ex_rd1_q;
    assign ex_rd2   = ex_rd2_q;
    assign ex_imm   = ex_imm_q;
    assign ex_rs1   = ex_rs1_q;
    assign ex_rs2   = ex_rs2_q;
    assign ex_rd    = ex_rd_q;
    assign ex_funct = ex_funct_q;
    assign halted   = halted_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: expected EX contents are queued when
// each ID instruction is driven and compared one cycle later.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        id_valid;
    logic [12:0] id_ctrl;
    logic [31:0] id_pc, id_rd1, id_rd2, id_imm;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic [9:0]  id_funct;
    logic        ex_flush;
    logic        ex_valid;
    logic [12:0] ex_ctrl;
    logic [31:0] ex_pc, ex_rd1, ex_rd2, ex_imm;
    logic [4:0]  ex_rs1, ex_rs2, ex_rd;
    logic [9:0]  ex_funct;
    logic        stall;
    logic        halted;

    always #5 clk = ~clk;

    id_ex_stage dut (
        .clk      (clk),
        .reset    (reset),
        .id_valid (id_valid),
        .id_ctrl  (id_ctrl),
        .id_pc    (id_pc),
        .id_rd1   (id_rd1),
        .id_rd2   (id_rd2),
        .id_imm   (id_imm),
        .id_rs1   (id_rs1),
        .id_rs2   (id_rs2),
        .id_rd    (id_rd),
        .id_funct (id_funct),
        .ex_flush (ex_flush),
        .ex_valid (ex_valid),
        .ex_ctrl  (ex_ctrl),
        .ex_pc    (ex_pc),
        .ex_rd1   (ex_rd1),
        .ex_rd2   (ex_rd2),
        .ex_imm   (ex_imm),
        .ex_rs1   (ex_rs1),
        .ex_rs2   (ex_rs2),
        .ex_rd    (ex_rd),
        .ex_funct (ex_funct),
        .stall    (stall),
        .halted   (halted)
    );

    typedef struct {
        logic [31:0] pc, rd1, rd2, imm;
        logic [4:0]  rs1, rs2, rd;
        logic [9:0]  funct;
    } pl_t;

    typedef struct {
        string       tag;
        logic        v;
        logic [12:0] ctrl;
        logic        halted;
        pl_t         pl;
    } exp_t;

    exp_t sb[$];
    pl_t  last_pl;
    int   n_checks = 0;
    int   n_fail   = 0;

    localparam logic [12:0] C_ADDI = 13'h0C9;
    localparam logic [12:0] C_LW   = 13'h01B;
    localparam logic [12:0] C_ADD  = 13'h088;
    localparam logic [12:0] C_HALT = 13'h1000;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [12:0] c, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] imm,
                         input logic [31:0] pc, input logic fl);
        id_valid = v;
        id_ctrl  = c;
        id_rs1   = rs1;
        id_rs2   = rs2;
        id_rd    = rd;
        id_imm   = imm;
        id_pc    = pc;
        id_rd1   = pc ^ 32'hA5A5_0000;
        id_rd2   = ~imm;
        id_funct = {rs2, rs1};
        ex_flush = fl;
    endtask

    task automatic stall_is(input string tag, input logic e);
        #1;
        check(tag, {31'd0, stall}, {31'd0, e});
    endtask

    task automatic exp_capture(input string tag, input logic v, input logic [12:0] c);
        exp_t e;
        last_pl = '{pc: id_pc, rd1: id_rd1, rd2: id_rd2, imm: id_imm,
                    rs1: id_rs1, rs2: id_rs2, rd: id_rd, funct: id_funct};
        e = '{tag: tag, v: v, ctrl: c, halted: 1'b0, pl: last_pl};
        sb.push_back(e);
    endtask

    task automatic exp_bubble(input string tag, input logic h);
        exp_t e;
        e = '{tag: tag, v: 1'b0, ctrl: 13'd0, halted: h, pl: last_pl};
        sb.push_back(e);
    endtask

    task automatic exp_reset(input string tag);
        exp_t e;
        last_pl = '{pc: 32'd0, rd1: 32'd0, rd2: 32'd0, imm: 32'd0,
                    rs1: 5'd0, rs2: 5'd0, rd: 5'd0, funct: 10'd0};
        e = '{tag: tag, v: 1'b0, ctrl: 13'd0, halted: 1'b0, pl: last_pl};
        sb.push_back(e);
    endtask

    task automatic tick();
        exp_t e;
        @(posedge clk);
        #1;
        check("sb_depth", sb.size(), 1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check({e.tag, ".valid"},  {31'd0, ex_valid}, {31'd0, e.v});
            check({e.tag, ".ctrl"},   {19'd0, ex_ctrl},  {19'd0, e.ctrl});
            check({e.tag, ".halted"}, {31'd0, halted},   {31'd0, e.halted});
            check({e.tag, ".pc"},     ex_pc,  e.pl.pc);
            check({e.tag, ".rd1"},    ex_rd1, e.pl.rd1);
            check({e.tag, ".rd2"},    ex_rd2, e.pl.rd2);
            check({e.tag, ".imm"},    ex_imm, e.pl.imm);
            check({e.tag, ".rs1"},    {27'd0, ex_rs1}, {27'd0, e.pl.rs1});
            check({e.tag, ".rs2"},    {27'd0, ex_rs2}, {27'd0, e.pl.rs2});
            check({e.tag, ".rd"},     {27'd0, ex_rd},  {27'd0, e.pl.rd});
            check({e.tag, ".funct"},  {22'd0, ex_funct}, {22'd0, e.pl.funct});
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset with an all-ones control word on a valid ID instruction.
        reset = 1'b1;
        drive(1'b1, 13'h1FFF, 5'd1, 5'd2, 5'd7, 32'h55, 32'h40, 1'b0);
        stall_is("rst_stall1", 1'b0); exp_reset("rst1"); tick();
        stall_is("rst_stall2", 1'b0); exp_reset("rst2"); tick();
        reset = 1'b0;

        // addi x5,x1,4
        drive(1'b1, C_ADDI, 5'd1, 5'd4, 5'd5, 32'd4, 32'h100, 1'b0);
        stall_is("addi_stall", 1'b0); exp_capture("addi", 1'b1, 13'h0C9); tick();

        // lw x6 ; followed by a dependent add using x6
        drive(1'b1, C_LW, 5'd1, 5'd2, 5'd6, 32'd8, 32'h104, 1'b0);
        stall_is("lw_stall", 1'b0); exp_capture("lw6", 1'b1, C_LW); tick();
        drive(1'b1, C_ADD, 5'd1, 5'd6, 5'd7, 32'd0, 32'h108, 1'b0);
`ifdef LOAD_USE_STALL_EN
        stall_is("lu_stall", 1'b1); exp_bubble("lu_bubble", 1'b0); tick();
        stall_is("lu_release", 1'b0);
`else
        stall_is("lu_nostall", 1'b0);
`endif
        exp_capture("lu_dep", 1'b1, C_ADD); tick();

        // Load into x0 never creates a hazard.
        drive(1'b1, C_LW, 5'd1, 5'd2, 5'd0, 32'hC, 32'h10C, 1'b0);
        stall_is("lw0_stall", 1'b0); exp_capture("lw0", 1'b1, C_LW); tick();
        drive(1'b1, C_ADD, 5'd0, 5'd0, 5'd9, 32'd0, 32'h110, 1'b0);
        stall_is("x0_dep_stall", 1'b0); exp_capture("x0_dep", 1'b1, C_ADD); tick();

        // Invalid ID slot: payload loads, controls forced to zero.
        drive(1'b0, C_ADDI, 5'd3, 5'd4, 5'd8, 32'd7, 32'h112, 1'b0);
        stall_is("inv_stall", 1'b0); exp_capture("invalid", 1'b0, 13'd0); tick();

        // Flush of a valid instruction.
        drive(1'b1, C_ADDI, 5'd1, 5'd2, 5'd10, 32'd5, 32'h114, 1'b1);
        stall_is("flush_stall", 1'b0); exp_bubble("flush", 1'b0); tick();

        // Flush together with a load-use hazard: no stall, just a bubble.
        drive(1'b1, C_LW, 5'd2, 5'd0, 5'd11, 32'h10, 32'h118, 1'b0);
        stall_is("lw11_stall", 1'b0); exp_capture("lw11", 1'b1, C_LW); tick();
        drive(1'b1, C_ADD, 5'd11, 5'd3, 5'd12, 32'd0, 32'h11C, 1'b1);
        stall_is("flush_hz_stall", 1'b0); exp_bubble("flush_hz", 1'b0); tick();

        // Halt squashed by flush must not start the drain.
        drive(1'b1, C_HALT, 5'd1, 5'd2, 5'd0, 32'd0, 32'h120, 1'b1);
        stall_is("halt_sq_stall", 1'b0); exp_bubble("halt_squashed", 1'b0); tick();
        drive(1'b1, C_ADDI, 5'd1, 5'd0, 5'd14, 32'd4, 32'h124, 1'b0);
        stall_is("post_sq_stall", 1'b0); exp_capture("post_squash", 1'b1, C_ADDI); tick();

        // Halt behind a load it depends on, then the drain sequence.
        drive(1'b1, C_LW, 5'd1, 5'd0, 5'd13, 32'h20, 32'h200, 1'b0);
        stall_is("lw13_stall", 1'b0); exp_capture("lw13", 1'b1, C_LW); tick();
        drive(1'b1, C_HALT, 5'd13, 5'd0, 5'd0, 32'd0, 32'h204, 1'b0);
`ifdef LOAD_USE_STALL_EN
        stall_is("halt_hz_stall", 1'b1); exp_bubble("halt_hz", 1'b0); tick();
        stall_is("halt_release", 1'b0);
`else
        stall_is("halt_nostall", 1'b0);
`endif
        exp_capture("halt", 1'b1, C_HALT); tick();
        drive(1'b1, C_ADDI, 5'd1, 5'd2, 5'd15, 32'd4, 32'h208, 1'b0);
        stall_is("drain_stall1", 1'b1); exp_bubble("drain1", 1'b0); tick();
        ex_flush = 1'b1;
        stall_is("drain_stall2", 1'b1); exp_bubble("drain2_flush", 1'b0); tick();
        ex_flush = 1'b0;
        stall_is("drain_stall3", 1'b1); exp_bubble("drain3", 1'b1); tick();
        stall_is("halted_stall1", 1'b1); exp_bubble("halted1", 1'b1); tick();
        stall_is("halted_stall2", 1'b1); exp_bubble("halted2", 1'b1); tick();

        // Reset out of HALTED, then normal capture resumes.
        reset = 1'b1;
        stall_is("rst_halted_stall", 1'b0); exp_reset("rst_halted"); tick();
        reset = 1'b0;
        drive(1'b1, C_ADDI, 5'd1, 5'd2, 5'd5, 32'd4, 32'h300, 1'b0);
        stall_is("resume_stall", 1'b0); exp_capture("resume", 1'b1, C_ADDI); tick();

        // Reset in the middle of a drain.
        drive(1'b1, C_HALT, 5'd1, 5'd2, 5'd0, 32'd0, 32'h304, 1'b0);
        stall_is("halt2_stall", 1'b0); exp_capture("halt2", 1'b1, C_HALT); tick();
        drive(1'b1, C_ADDI, 5'd1, 5'd2, 5'd6, 32'd4, 32'h308, 1'b0);
        stall_is("drain_b_stall", 1'b1); exp_bubble("drain_b", 1'b0); tick();
        reset = 1'b1;
        stall_is("rst_drain_stall", 1'b0); exp_reset("rst_drain"); tick();
        reset = 1'b0;
        stall_is("after_rst_stall", 1'b0); exp_capture("after_rst", 1'b1, C_ADDI); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
